// File: rtl/fifo_ser_tx.sv
// fifo_ser_tx: drains a FIFO through empty/dequeue and shifts each word out as a serial frame
// (start, data LSB-first, optional even parity, stop). Parity is built when FIFO_SER_TX_PARITY_EN is defined.
module fifo_ser_tx #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned BAUD_DIV = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             empty,
    input  logic [WIDTH-1:0] din,
    output logic             dequeue,
    output logic             txd,
    output logic             busy
);

    localparam int unsigned BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned BIT_W  = $clog2(WIDTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef FIFO_SER_TX_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd3
    } state_e;

    state_e             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [WIDTH-1:0]   shifted;
    logic               txd_q, txd_d;
    logic               busy_q;
    logic               baud_tick;
`ifdef FIFO_SER_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif

    // State and datapath registers; reset forces the line idle at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
`ifdef FIFO_SER_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            txd_q    <= txd_d;
            busy_q   <= (state_d != S_IDLE);
`ifdef FIFO_SER_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next state; txd_d is the level the line takes in the cycle after this edge.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        txd_d     = txd_q;
        dequeue   = 1'b0;
`ifdef FIFO_SER_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        baud_tick = (baud_q == BAUD_LAST);
        shifted   = shreg_q >> 1;

        if (state_q != S_IDLE) begin
            baud_d = baud_tick ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (!empty && rst) begin
                    dequeue  = 1'b1;
                    shreg_d  = din;
                    baud_d   = '0;
                    bit_d    = '0;
                    state_d  = S_START;
                    txd_d    = 1'b0;
`ifdef FIFO_SER_TX_PARITY_EN
                    parity_d = ^din;
`endif
                end
            end
            S_START: begin
                if (baud_tick) begin
                    state_d = S_DATA;
                    txd_d   = shreg_q[0];
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    shreg_d = shifted;
                    bit_d   = bit_q + BIT_W'(1);
                    if (bit_q == BIT_LAST) begin
`ifdef FIFO_SER_TX_PARITY_EN
                        state_d = S_PARITY;
                        txd_d   = parity_q;
`else
                        state_d = S_STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        txd_d = shifted[0];
                    end
                end
            end
`ifdef FIFO_SER_TX_PARITY_EN
            S_PARITY: begin
                if (baud_tick) begin
                    state_d = S_STOP;
                    txd_d   = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (baud_tick) begin
                    state_d = S_IDLE;
                    txd_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    assign txd  = txd_q;
    assign busy = busy_q;

endmodule
